// File: rtl/alu_pkg.sv
// Shared widths and FSM state encoding for the shared-ALU arbiter.
package alu_pkg;
   localparam int ALU_DW  = 32;
   localparam int ALU_RW  = 64;
   localparam int ALU_SHW = 5;
   localparam int ALU_OPW = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot grant: first set request found searching upward from ptr (wrapping).
// With ptr tied to zero this degenerates to lowest-index-wins fixed priority.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  grant
);

   logic          found;
   logic [PW-1:0] idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < N; i++) begin
         idx = PW'((int'(ptr) + i) % N);
         if (en && !found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters, one operation in flight at a time.
// ALU_ARB_RR_EN defined: round-robin grant pointer; undefined: fixed priority, no pointer register.
//
// state | meaning
// IDLE  | waiting for a request; grant is combinational, operands captured on accept
// EXEC  | ALU driven with captured operands, cnt counts down ALU latency
// RESP  | result held on rsp_data, rsp_valid[g] high until rsp_ready[g]
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ALU_LAT = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [ALU_DW*NUM_REQ-1:0]  req_a,
   input  logic [ALU_DW*NUM_REQ-1:0]  req_b,
   input  logic [ALU_SHW*NUM_REQ-1:0] req_r,
   input  logic [ALU_OPW*NUM_REQ-1:0] req_op,
   output logic [NUM_REQ-1:0]         rsp_valid,
   input  logic [NUM_REQ-1:0]         rsp_ready,
   output logic [ALU_RW-1:0]          rsp_data,
   output logic [ALU_DW-1:0]          alu_a,
   output logic [ALU_DW-1:0]          alu_b,
   output logic [ALU_SHW-1:0]         alu_r,
   output logic [ALU_OPW-1:0]         alu_op,
   input  logic [ALU_RW-1:0]          alu_out,
   output logic                       busy
);

   localparam int PW = $clog2(NUM_REQ);
   localparam int CW = $clog2(ALU_LAT + 1);
   localparam logic [CW-1:0] LAT_LD = CW'(ALU_LAT);

   state_t              state, state_nxt;
   logic [CW-1:0]       cnt;
   logic [PW-1:0]       ptr, gnt_idx, win_idx;
   logic [NUM_REQ-1:0]  grant;
   logic                accept;

   rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr_arbiter (
      .req   (req_valid),
      .ptr   (ptr),
      .en    (state == IDLE),
      .grant (grant)
   );

   assign req_ready = grant;
   assign accept    = |grant;
   assign busy      = (state != IDLE);

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) win_idx = PW'(i);
      end
   end

`ifdef ALU_ARB_RR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (accept) begin
         ptr <= (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
      end
   end
`else
   assign ptr = '0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = EXEC;
         EXEC:    if (cnt == CW'(1)) state_nxt = RESP;
         RESP:    if (rsp_ready[gnt_idx]) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rsp_valid = '0;
      if (state == RESP) rsp_valid[gnt_idx] = 1'b1;
   end

   // alu_* are the operand registers themselves, so they hold outside EXEC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         gnt_idx  <= '0;
         alu_a    <= '0;
         alu_b    <= '0;
         alu_r    <= '0;
         alu_op   <= '0;
         rsp_data <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            alu_a   <= req_a[int'(win_idx)*ALU_DW +: ALU_DW];
            alu_b   <= req_b[int'(win_idx)*ALU_DW +: ALU_DW];
            alu_r   <= req_r[int'(win_idx)*ALU_SHW +: ALU_SHW];
            alu_op  <= req_op[int'(win_idx)*ALU_OPW +: ALU_OPW];
            gnt_idx <= win_idx;
            cnt     <= LAT_LD;
         end else if (state == EXEC) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) rsp_data <= alu_out;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: scoreboard of expected responses, one task per scenario.
module tb_alu_arbiter;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
   logic [127:0]  req_a, req_b;
   logic [19:0]   req_r;
   logic [15:0]   req_op;
   logic [63:0]   rsp_data, alu_out;
   logic [31:0]   alu_a, alu_b;
   logic [4:0]    alu_r;
   logic [3:0]    alu_op;
   logic          busy;

   logic [N-1:0]  req_valid3, req_ready3, rsp_valid3, rsp_ready3;
   logic [127:0]  req_a3, req_b3;
   logic [19:0]   req_r3;
   logic [15:0]   req_op3;
   logic [63:0]   rsp_data3, alu_out3, sum3, p1, p2;
   logic [31:0]   alu_a3, alu_b3;
   logic [4:0]    alu_r3;
   logic [3:0]    alu_op3;
   logic          busy3;

   typedef struct {
      int          idx;
      logic [63:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   // ALU model: a+b zero-extended, with ALU_LAT-1 pipeline stages ahead of the
   // arbiter's own result capture (none for latency 1, two for latency 3).
   assign alu_out  = {32'd0, alu_a} + {32'd0, alu_b};
   assign sum3     = {32'd0, alu_a3} + {32'd0, alu_b3};
   always @(posedge clk) begin
      p1 <= sum3;
      p2 <= p1;
   end
   assign alu_out3 = p2;

   alu_arbiter #(.NUM_REQ(N), .ALU_LAT(1)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_r(req_r), .req_op(req_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r), .alu_op(alu_op),
      .alu_out(alu_out), .busy(busy)
   );

   alu_arbiter #(.NUM_REQ(N), .ALU_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
      .req_a(req_a3), .req_b(req_b3), .req_r(req_r3), .req_op(req_op3),
      .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3),
      .alu_a(alu_a3), .alu_b(alu_b3), .alu_r(alu_r3), .alu_op(alu_op3),
      .alu_out(alu_out3), .busy(busy3)
   );

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, input logic [3:0] op);
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
      req_r[5*i +: 5]   = r;
      req_op[4*i +: 4]  = op;
   endtask

   // waits (bounded) for any rsp_valid; returns the number of negedges waited
   task automatic wait_rsp(output int n);
      n = 0;
      do begin
         @(negedge clk); #1;
         n++;
      end while (rsp_valid == '0 && n < 20);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk); #1;
      n_checks++; if (req_ready !== 4'b0) $display("FAIL reset_req_ready got %b want 0000", req_ready); else n_pass++;
      n_checks++; if (rsp_valid !== 4'b0) $display("FAIL reset_rsp_valid got %b want 0000", rsp_valid); else n_pass++;
      n_checks++; if (rsp_data !== 64'd0) $display("FAIL reset_rsp_data got %0h want 0", rsp_data); else n_pass++;
      n_checks++; if ({alu_a, alu_b} !== 64'd0) $display("FAIL reset_alu_ab got %0h want 0", {alu_a, alu_b}); else n_pass++;
      n_checks++; if ({alu_r, alu_op} !== 9'd0) $display("FAIL reset_alu_r_op got %0h want 0", {alu_r, alu_op}); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      int   n;
      exp_t e;
      set_req(0, 32'd30, 32'd20, 5'd0, 4'd0);
      req_valid = 4'b0001;
      #1;
      n_checks++; if (req_ready !== 4'b0001) $display("FAIL single_grant got %b want 0001", req_ready); else n_pass++;
      sb.push_back('{0, 64'd50});
      @(negedge clk);
      req_valid = '0;
      #1;
      n_checks++; if (alu_a !== 32'd30) $display("FAIL single_alu_a got %0d want 30", alu_a); else n_pass++;
      n_checks++; if (alu_b !== 32'd20) $display("FAIL single_alu_b got %0d want 20", alu_b); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL single_busy got %b want 1", busy); else n_pass++;
      wait_rsp(n);
      n_checks++; if (n + 1 !== 2) $display("FAIL single_latency got %0d want 2", n + 1); else n_pass++;
      e = sb.pop_front();
      n_checks++; if (rsp_valid !== 4'(1 << e.idx)) $display("FAIL single_rsp_valid got %b want %b", rsp_valid, 4'(1 << e.idx)); else n_pass++;
      n_checks++; if (rsp_data !== e.data) $display("FAIL single_rsp_data got %0d want %0d", rsp_data, e.data); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (busy !== 1'b0) $display("FAIL single_idle got busy=%b want 0", busy); else n_pass++;
   endtask

   task automatic test_contention();
      int   n, g;
      exp_t e;
      rst_n = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, 32'(i), 32'd10, 5'd0, 4'd0);
      req_valid = '1;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      for (int k = 0; k < N; k++) begin
`ifdef ALU_ARB_RR_EN
         g = k;
`else
         g = 0;
`endif
         n_checks++; if (req_ready !== 4'(1 << g)) $display("FAIL contention_grant%0d got %b want %b", k, req_ready, 4'(1 << g)); else n_pass++;
         sb.push_back('{g, 64'(g + 10)});
         @(negedge clk);
`ifdef ALU_ARB_RR_EN
         req_valid[g] = 1'b0;
`endif
         wait_rsp(n);
         e = sb.pop_front();
         n_checks++; if (rsp_valid !== 4'(1 << e.idx)) $display("FAIL contention_rsp_valid%0d got %b want %b", k, rsp_valid, 4'(1 << e.idx)); else n_pass++;
         n_checks++; if (rsp_data !== e.data) $display("FAIL contention_rsp_data%0d got %0d want %0d", k, rsp_data, e.data); else n_pass++;
         @(negedge clk); #1;
      end
      req_valid = '0;
   endtask

   task automatic test_backpressure();
      int   n;
      exp_t e;
      set_req(1, 32'd40, 32'd24, 5'd0, 4'd0);
      set_req(3, 32'd1, 32'd1, 5'd0, 4'd0);
      rsp_ready = '0;
      req_valid = 4'b0010;
      #1;
      n_checks++; if (req_ready !== 4'b0010) $display("FAIL bp_grant got %b want 0010", req_ready); else n_pass++;
      sb.push_back('{1, 64'd64});
      @(negedge clk);
      req_valid = 4'b1000;
      wait_rsp(n);
      e = sb.pop_front();
      for (int c = 0; c < 5; c++) begin
         n_checks++; if (rsp_valid !== 4'(1 << e.idx)) $display("FAIL bp_rsp_valid c%0d got %b want %b", c, rsp_valid, 4'(1 << e.idx)); else n_pass++;
         n_checks++; if (rsp_data !== e.data) $display("FAIL bp_rsp_data c%0d got %0d want %0d", c, rsp_data, e.data); else n_pass++;
         n_checks++; if (req_ready !== 4'b0) $display("FAIL bp_no_grant c%0d got %b want 0000", c, req_ready); else n_pass++;
         n_checks++; if (busy !== 1'b1) $display("FAIL bp_busy c%0d got %b want 1", c, busy); else n_pass++;
         @(negedge clk); #1;
      end
   endtask

   task automatic test_misrouted();
      int   n;
      exp_t e;
      rsp_ready = 4'b0100;
      repeat (2) begin
         @(negedge clk); #1;
         n_checks++; if (rsp_valid !== 4'b0010) $display("FAIL misrouted_rsp_valid got %b want 0010", rsp_valid); else n_pass++;
         n_checks++; if (rsp_data !== 64'd64) $display("FAIL misrouted_rsp_data got %0d want 64", rsp_data); else n_pass++;
      end
      rsp_ready = 4'b0010;
      @(negedge clk); #1;
      n_checks++; if (rsp_valid !== 4'b0) $display("FAIL misrouted_release got %b want 0000", rsp_valid); else n_pass++;
      n_checks++; if (req_ready !== 4'b1000) $display("FAIL misrouted_next_grant got %b want 1000", req_ready); else n_pass++;
      sb.push_back('{3, 64'd2});
      rsp_ready = '1;
      @(negedge clk);
      req_valid = '0;
      wait_rsp(n);
      e = sb.pop_front();
      n_checks++; if (rsp_valid !== 4'(1 << e.idx)) $display("FAIL misrouted_rsp3_valid got %b want %b", rsp_valid, 4'(1 << e.idx)); else n_pass++;
      n_checks++; if (rsp_data !== e.data) $display("FAIL misrouted_rsp3_data got %0d want %0d", rsp_data, e.data); else n_pass++;
      @(negedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int   n, pulses;
      exp_t e;
      set_req(0, 32'd34, 32'd0, 5'd4, 4'd4);
      req_valid = 4'b0001;
      #1;
      n_checks++; if (req_ready !== 4'b0001) $display("FAIL rmid_grant got %b want 0001", req_ready); else n_pass++;
      @(negedge clk);
      req_valid = '0;
      #1;
      n_checks++; if ({alu_a, alu_r, alu_op} !== {32'd34, 5'd4, 4'd4}) $display("FAIL rmid_alu got %0h want %0h", {alu_a, alu_r, alu_op}, {32'd34, 5'd4, 4'd4}); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy); else n_pass++;
      n_checks++; if (rsp_data !== 64'd0) $display("FAIL rmid_rsp_data got %0d want 0", rsp_data); else n_pass++;
      n_checks++; if ({alu_a, alu_b, alu_r, alu_op} !== 73'd0) $display("FAIL rmid_alu_clear got %0h want 0", {alu_a, alu_b, alu_r, alu_op}); else n_pass++;
      n_checks++; if ({req_ready, rsp_valid} !== 8'd0) $display("FAIL rmid_handshake got %b want 0", {req_ready, rsp_valid}); else n_pass++;
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      pulses = 0;
      repeat (6) begin
         @(negedge clk); #1;
         if (rsp_valid !== 4'b0) pulses++;
      end
      n_checks++; if (pulses !== 0) $display("FAIL rmid_no_rsp got %0d pulses want 0", pulses); else n_pass++;
      set_req(2, 32'd5, 32'd5, 5'd0, 4'd0);
      req_valid = 4'b0101;
      #1;
      n_checks++; if (req_ready !== 4'b0001) $display("FAIL rmid_ptr_reset got %b want 0001", req_ready); else n_pass++;
      sb.push_back('{0, 64'd34});
      @(negedge clk);
      req_valid = '0;
      wait_rsp(n);
      e = sb.pop_front();
      n_checks++; if (rsp_valid !== 4'(1 << e.idx)) $display("FAIL rmid_rsp_valid got %b want %b", rsp_valid, 4'(1 << e.idx)); else n_pass++;
      n_checks++; if (rsp_data !== e.data) $display("FAIL rmid_rsp_data2 got %0d want %0d", rsp_data, e.data); else n_pass++;
      @(negedge clk); #1;
   endtask

   task automatic test_lat3();
      int   n;
      exp_t e;
      req_a3[31:0] = 32'd7;
      req_b3[31:0] = 32'd8;
      req_valid3   = 4'b0001;
      #1;
      n_checks++; if (req_ready3 !== 4'b0001) $display("FAIL lat3_grant got %b want 0001", req_ready3); else n_pass++;
      sb.push_back('{0, 64'd15});
      n = 0;
      @(negedge clk);
      req_valid3 = '0;
      #1;
      n = 1;
      while (rsp_valid3 == '0 && n < 20) begin
         @(negedge clk); #1;
         n++;
      end
      e = sb.pop_front();
      n_checks++; if (n !== 4) $display("FAIL lat3_latency got %0d want 4", n); else n_pass++;
      n_checks++; if (rsp_valid3 !== 4'(1 << e.idx)) $display("FAIL lat3_rsp_valid got %b want %b", rsp_valid3, 4'(1 << e.idx)); else n_pass++;
      n_checks++; if (rsp_data3 !== e.data) $display("FAIL lat3_rsp_data got %0d want %0d", rsp_data3, e.data); else n_pass++;
   endtask

   initial begin
      req_valid  = '0;
      rsp_ready  = '1;
      req_a      = '0;
      req_b      = '0;
      req_r      = '0;
      req_op     = '0;
      req_valid3 = '0;
      rsp_ready3 = '1;
      req_a3     = '0;
      req_b3     = '0;
      req_r3     = '0;
      req_op3    = '0;
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_misrouted();
      test_reset_mid();
      test_lat3();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got no completion want finish before 200000");
      $fatal(1);
   end

endmodule
